pipe_ctrl_unit: RTL and testbench
=================================

PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 Parameter REG_W, default 5, register-specifier width.
REQ-002 Parameter HALT_REG, default 17, register number read by ECALL for the halt test.
REQ-003 Parameter HALT_DRAIN, default 0, extra cycles between ECALL leaving WB and is_halted rising.
REQ-004 The block SHALL use one clock and a synchronous active-high reset:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
REQ-005 Decode-stage inputs:
- id_valid  in  1  ID holds a real instruction.
- id_opcode  in  7  instruction[6:0].
- id_rs1, id_rs2, id_rd  in  REG_W each  register specifiers.
- id_halt_cond  in  1  forwarded value of x[HALT_REG] equals 10.
REQ-006 Event inputs:
- ex_redirect  in  1  branch/jump in EX changes PC.
- mem_ready  in  1  data memory completes the access in MEM this cycle.
REQ-007 Hazard outputs:
- pc_write  out  1  PC may update.
- if_id_write  out  1  IF/ID may load.
- if_id_flush  out  1  IF/ID becomes a bubble.
REQ-008 EX-stage outputs: ex_alu_src, ex_branch, ex_is_jal, ex_is_jalr  out  1 each.
REQ-009 MEM-stage outputs: mem_read, mem_write  out  1 each.
REQ-010 WB-stage outputs: wb_mem_to_reg, wb_write_enable, wb_pc_to_reg  out  1 each; wb_rd  out  REG_W.
REQ-011 is_halted  out  1  sticky halt flag.

Function
REQ-012 Decoding SHALL follow the RV32I table, all bits 0 by default:
- R-type ALU: write_enable.
- I-type ALU: alu_src, write_enable.
- LOAD: mem_read, mem_to_reg, alu_src, write_enable.
- STORE: mem_write, alu_src.
- BRANCH: branch.
- JAL: is_jal, write_enable, pc_to_reg.
- JALR: is_jalr, write_enable, pc_to_reg, alu_src.
- ECALL: is_ecall.
- Unknown opcode or id_valid=0: bubble (all zero).
REQ-013 Decoded bits SHALL be registered through ID/EX, EX/MEM and MEM/WB, along with rd, valid and is_ecall, and SHALL be presented at the stage that consumes them, for a latency of 1/2/3 cycles.
REQ-014 Writes to rd=0 SHALL force write_enable=0 at decode.
REQ-015 Load-use stall SHALL trigger when ID/EX is a valid load, its rd!=0, and its rd matches a used source in ID:
- rs1 is used by all types except JAL.
- rs2 is used by R, STORE and BRANCH.
- Response: pc_write=0, if_id_write=0, bubble into ID/EX, for exactly one cycle.
REQ-016 ECALL stall SHALL trigger when ECALL is in ID and a valid write to HALT_REG sits in ID/EX, or a valid load to HALT_REG sits in EX/MEM.
- Response: same as REQ-015, repeated until the condition clears.
REQ-017 ex_redirect SHALL set if_id_flush=1 and insert a bubble into ID/EX next edge, overriding any stall in the same cycle.
REQ-018 While MEM holds a valid read/write and mem_ready=0, all stage registers SHALL hold and pc_write=if_id_write=0.
- In that state, redirect and stall have no effect.
- Priority: memory freeze > redirect > ECALL stall > load-use stall.
REQ-019 ECALL with id_halt_cond=1 entering ID/EX SHALL set a halt-pending flag.
- While pending: pc_write=if_id_write=0, and subsequent decodes are bubbles.
- A redirect in the same cycle cancels the ECALL; the flag is not set.
REQ-020 is_halted SHALL rise HALT_DRAIN+1 cycles after the halting ECALL leaves MEM/WB, driven by a counter, and SHALL stay 1 until reset.
- After is_halted, all hazard outputs stay 0.
REQ-021 ECALL with id_halt_cond=0 SHALL pass as a bubble without effect.

Reset
REQ-022 On reset (synchronous, at the clock edge):
- All stage registers become bubbles.
- The halt flag and drain counter clear.
- is_halted=0.
- All control outputs are 0, except pc_write=1 and if_id_write=1.
REQ-023 Reset asserted mid-stall, mid-freeze or mid-drain SHALL override every other event in that cycle.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- LOAD rd=5, then ADD rs1=5: one cycle pc_write=0; ID/EX bubble; ADD reaches EX a cycle later; wb_write_enable=1 with wb_rd=5 three cycles after LOAD decode.
- LOAD rd=0, then ADD rs1=0: no stall; LOAD's wb_write_enable=0.
- Valid load in MEM, mem_ready=0 for 3 cycles: all outputs frozen 3 cycles; ex_redirect pulsed in the middle is ignored.
- ex_redirect with load-use hazard in the same cycle: if_id_flush=1; no stall cycle.
- ADDI rd=17, then ECALL with halt_cond=1 (HALT_DRAIN=0): one stall cycle, then is_halted=1 one cycle after ECALL leaves WB; stays 1 across 10 cycles; reset clears it.
- ECALL with halt_cond=1 while ex_redirect=1: flushed; is_halted stays 0.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit
//   Control path for a 5-stage RV32I pipeline. It decodes the instruction in
//   ID, carries the control bits through ID/EX, EX/MEM and MEM/WB, and drives
//   the hazard controls: load-use stall, ECALL halt-register stall, redirect
//   flush, memory freeze, and the halt sequence.
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   id_valid/opcode/rs1/rs2/rd decode-stage instruction fields
//   id_halt_cond               forwarded x[HALT_REG] == 10
//   ex_redirect                branch/jump in EX changes PC
//   mem_ready                  data memory completes the MEM access this cycle
//   pc_write, if_id_write      PC / IF/ID load enables
//   if_id_flush                turn IF/ID into a bubble
//   ex_*, mem_*, wb_*          per-stage control bits
//   is_halted                  sticky halt flag
module pipe_ctrl_unit #(
  parameter int REG_W      = 5,
  parameter int HALT_REG   = 17,
  parameter int HALT_DRAIN = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_halt_cond,
  input  logic             ex_redirect,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             ex_alu_src,
  output logic             ex_branch,
  output logic             ex_is_jal,
  output logic             ex_is_jalr,
  output logic             mem_read,
  output logic             mem_write,
  output logic             wb_mem_to_reg,
  output logic             wb_write_enable,
  output logic             wb_pc_to_reg,
  output logic [REG_W-1:0] wb_rd,
  output logic             is_halted
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  localparam logic [REG_W-1:0] HALT_RD = REG_W'(HALT_REG);
  localparam int CNT_W = (HALT_DRAIN > 0) ? $clog2(HALT_DRAIN + 1) : 1;

  // Each stage register keeps only the bits still needed downstream.
  typedef struct packed {
    logic             valid;
    logic             is_ecall;
    logic             mem_to_reg;
    logic             write_enable;
    logic             pc_to_reg;
    logic [REG_W-1:0] rd;
  } wb_ctl_t;

  typedef struct packed {
    wb_ctl_t wb;
    logic    mem_read;
    logic    mem_write;
  } mem_ctl_t;

  typedef struct packed {
    mem_ctl_t m;
    logic     alu_src;
    logic     branch;
    logic     is_jal;
    logic     is_jalr;
  } ex_ctl_t;

  ex_ctl_t    dec;
  ex_ctl_t    ide_q, ide_d;
  mem_ctl_t   exm_q, exm_d;
  wb_ctl_t    mwb_q, mwb_d;
  logic       halt_pend_q, halt_pend_d;
  logic       drain_act_q, drain_act_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic       halted_q, halted_d;

  logic rs1_used, rs2_used, id_is_ecall;
  logic frozen, load_use, ecall_stall, hold_id;

  // Decode. A non-halting ECALL decodes to a bubble; it still counts as an
  // ECALL for the stall check because its halt_cond may be stale.
  always_comb begin
    dec         = '0;
    rs1_used    = 1'b0;
    rs2_used    = 1'b0;
    id_is_ecall = id_valid && (id_opcode == OP_SYS);
    if (id_valid) begin
      case (id_opcode)
        OP_R: begin
          dec.m.wb.valid = 1'b1; dec.m.wb.write_enable = 1'b1;
          rs1_used = 1'b1; rs2_used = 1'b1;
        end
        OP_I: begin
          dec.m.wb.valid = 1'b1; dec.alu_src = 1'b1; dec.m.wb.write_enable = 1'b1;
          rs1_used = 1'b1;
        end
        OP_LOAD: begin
          dec.m.wb.valid = 1'b1; dec.m.mem_read = 1'b1; dec.m.wb.mem_to_reg = 1'b1;
          dec.alu_src = 1'b1; dec.m.wb.write_enable = 1'b1;
          rs1_used = 1'b1;
        end
        OP_STORE: begin
          dec.m.wb.valid = 1'b1; dec.m.mem_write = 1'b1; dec.alu_src = 1'b1;
          rs1_used = 1'b1; rs2_used = 1'b1;
        end
        OP_BRANCH: begin
          dec.m.wb.valid = 1'b1; dec.branch = 1'b1;
          rs1_used = 1'b1; rs2_used = 1'b1;
        end
        OP_JAL: begin
          dec.m.wb.valid = 1'b1; dec.is_jal = 1'b1;
          dec.m.wb.write_enable = 1'b1; dec.m.wb.pc_to_reg = 1'b1;
        end
        OP_JALR: begin
          dec.m.wb.valid = 1'b1; dec.is_jalr = 1'b1; dec.alu_src = 1'b1;
          dec.m.wb.write_enable = 1'b1; dec.m.wb.pc_to_reg = 1'b1;
          rs1_used = 1'b1;
        end
        OP_SYS: begin
          rs1_used = 1'b1;
          if (id_halt_cond) begin
            dec.m.wb.valid = 1'b1; dec.m.wb.is_ecall = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (dec.m.wb.valid) dec.m.wb.rd = id_rd;
    if (id_rd == '0)    dec.m.wb.write_enable = 1'b0;
  end

  always_comb begin
    frozen   = exm_q.wb.valid && (exm_q.mem_read || exm_q.mem_write) && !mem_ready;
    load_use = ide_q.m.wb.valid && ide_q.m.mem_read && (ide_q.m.wb.rd != '0) &&
               ((rs1_used && (id_rs1 == ide_q.m.wb.rd)) ||
                (rs2_used && (id_rs2 == ide_q.m.wb.rd)));
    ecall_stall = id_is_ecall &&
                  ((ide_q.m.wb.valid && ide_q.m.wb.write_enable && (ide_q.m.wb.rd == HALT_RD)) ||
                   (exm_q.wb.valid && exm_q.mem_read && (exm_q.wb.rd == HALT_RD)));
    hold_id  = ecall_stall || load_use || halt_pend_q;
  end

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    ide_d       = ide_q;
    exm_d       = exm_q;
    mwb_d       = mwb_q;
    halt_pend_d = halt_pend_q;
    drain_act_d = drain_act_q;
    drain_cnt_d = drain_cnt_q;
    halted_d    = halted_q;
    if (reset) begin
      ide_d       = '0;
      exm_d       = '0;
      mwb_d       = '0;
      halt_pend_d = 1'b0;
      drain_act_d = 1'b0;
      drain_cnt_d = '0;
      halted_d    = 1'b0;
    end else begin
      // Hazard outputs, highest priority first.
      if (halted_q || frozen) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
      end else if (ex_redirect) begin
        if_id_flush = 1'b1;
      end else if (hold_id) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
      end

      if (!frozen) begin
        mwb_d = exm_q.wb;
        exm_d = ide_q.m;
        if (ex_redirect || hold_id) begin
          ide_d = '0;
        end else begin
          ide_d = dec;
          if (dec.m.wb.is_ecall) halt_pend_d = 1'b1;
        end
        // Halting ECALL leaves MEM/WB on this edge: start the drain count.
        if (mwb_q.valid && mwb_q.is_ecall) begin
          drain_act_d = 1'b1;
          drain_cnt_d = '0;
        end
      end

      if (drain_act_q) begin
        if (drain_cnt_q == CNT_W'(HALT_DRAIN)) begin
          halted_d    = 1'b1;
          drain_act_d = 1'b0;
        end else begin
          drain_cnt_d = drain_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    ide_q       <= ide_d;
    exm_q       <= exm_d;
    mwb_q       <= mwb_d;
    halt_pend_q <= halt_pend_d;
    drain_act_q <= drain_act_d;
    drain_cnt_q <= drain_cnt_d;
    halted_q    <= halted_d;
  end

  assign ex_alu_src      = ide_q.alu_src;
  assign ex_branch       = ide_q.branch;
  assign ex_is_jal       = ide_q.is_jal;
  assign ex_is_jalr      = ide_q.is_jalr;
  assign mem_read        = exm_q.mem_read;
  assign mem_write       = exm_q.mem_write;
  assign wb_mem_to_reg   = mwb_q.mem_to_reg;
  assign wb_write_enable = mwb_q.write_enable;
  assign wb_pc_to_reg    = mwb_q.pc_to_reg;
  assign wb_rd           = mwb_q.rd;
  assign is_halted       = halted_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit (default parameters, HALT_DRAIN=0).
module tb_pipe_ctrl_unit;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_halt_cond, ex_redirect, mem_ready;
  logic       pc_write, if_id_write, if_id_flush;
  logic       ex_alu_src, ex_branch, ex_is_jal, ex_is_jalr;
  logic       mem_read, mem_write;
  logic       wb_mem_to_reg, wb_write_enable, wb_pc_to_reg;
  logic [4:0] wb_rd;
  logic       is_halted;

  logic [2:0] hz;
  logic [3:0] exo;
  logic [1:0] memo;
  logic [2:0] wbo;
  assign hz   = {pc_write, if_id_write, if_id_flush};
  assign exo  = {ex_alu_src, ex_branch, ex_is_jal, ex_is_jalr};
  assign memo = {mem_read, mem_write};
  assign wbo  = {wb_mem_to_reg, wb_write_enable, wb_pc_to_reg};

  int tests = 0;
  int fails = 0;

  pipe_ctrl_unit dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_halt_cond(id_halt_cond), .ex_redirect(ex_redirect), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_is_jal(ex_is_jal),
    .ex_is_jalr(ex_is_jalr), .mem_read(mem_read), .mem_write(mem_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_write_enable(wb_write_enable),
    .wb_pc_to_reg(wb_pc_to_reg), .wb_rd(wb_rd), .is_halted(is_halted)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd, input logic hc);
    id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_halt_cond = hc;
  endtask

  task automatic nop;
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    nop; ex_redirect = 1'b0; mem_ready = 1'b1;
    repeat (4) tick;
  endtask

  task automatic test_reset;
    reset = 1'b1; ex_redirect = 1'b1; mem_ready = 1'b1;
    drive(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b0);
    #1;
    tests++;
    if (hz !== 3'b110) begin fails++; $display("FAIL rst_active_hz got %b exp %b", hz, 3'b110); end
    tick;
    reset = 1'b0; ex_redirect = 1'b0; nop;
    #1;
    tests++;
    if (hz !== 3'b110) begin fails++; $display("FAIL rst_hz got %b exp %b", hz, 3'b110); end
    tests++;
    if ({exo, memo, wbo, wb_rd, is_halted} !== 15'd0)
      begin fails++; $display("FAIL rst_stages got %b exp 0", {exo, memo, wbo, wb_rd, is_halted}); end
    tick;
  endtask

  task automatic test_decode;
    logic [6:0] ops [9];
    logic [8:0] expv [9];
    ops  = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, 7'b0000000, OP_R};
    // {alu_src,branch,is_jal,is_jalr}, {mem_read,mem_write}, {mem_to_reg,we,pc_to_reg}
    expv = '{9'b0000_00_010, 9'b1000_00_010, 9'b1000_10_110, 9'b1000_01_000,
             9'b0100_00_000, 9'b0010_00_011, 9'b1001_00_011, 9'b0000_00_000,
             9'b0000_00_000};
    for (int k = 0; k < 12; k++) begin
      if (k < 9) drive(1'b1, ops[k], 5'd0, 5'd0, (k == 8) ? 5'd0 : 5'(k + 1), 1'b0);
      else nop;
      #1;
      tests++;
      if (hz !== 3'b110) begin fails++; $display("FAIL dec_hz[%0d] got %b exp %b", k, hz, 3'b110); end
      if (k >= 1 && k <= 9) begin
        tests++;
        if (exo !== expv[k-1][8:5])
          begin fails++; $display("FAIL dec_ex[%0d] got %b exp %b", k - 1, exo, expv[k-1][8:5]); end
      end
      if (k >= 2 && k <= 10) begin
        tests++;
        if (memo !== expv[k-2][4:3])
          begin fails++; $display("FAIL dec_mem[%0d] got %b exp %b", k - 2, memo, expv[k-2][4:3]); end
      end
      if (k >= 3) begin
        tests++;
        if (wbo !== expv[k-3][2:0])
          begin fails++; $display("FAIL dec_wb[%0d] got %b exp %b", k - 3, wbo, expv[k-3][2:0]); end
        if (expv[k-3][1]) begin
          tests++;
          if (wb_rd !== 5'(k - 2))
            begin fails++; $display("FAIL dec_wb_rd[%0d] got %0d exp %0d", k - 3, wb_rd, k - 2); end
        end
      end
      tick;
    end
  endtask

  task automatic test_load_use;
    drive(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b0);
    #1; tests++;
    if (hz !== 3'b110) begin fails++; $display("FAIL lu_c0_hz got %b exp %b", hz, 3'b110); end
    tick;
    drive(1'b1, OP_R, 5'd5, 5'd2, 5'd6, 1'b0);
    #1; tests++;
    if (hz !== 3'b000) begin fails++; $display("FAIL lu_stall_hz got %b exp %b", hz, 3'b000); end
    tests++;
    if (exo !== 4'b1000) begin fails++; $display("FAIL lu_stall_ex got %b exp %b", exo, 4'b1000); end
    tick;
    #1; tests++;
    if (hz !== 3'b110) begin fails++; $display("FAIL lu_resume_hz got %b exp %b", hz, 3'b110); end
    tests++;
    if ({exo, memo} !== 6'b0000_10)
      begin fails++; $display("FAIL lu_bubble got %b exp %b", {exo, memo}, 6'b0000_10); end
    tick;
    nop;
    #1; tests++;
    if ({wbo, wb_rd} !== {3'b110, 5'd5})
      begin fails++; $display("FAIL lu_load_wb got %b exp %b", {wbo, wb_rd}, {3'b110, 5'd5}); end
    tick;
    tests++;
    if (wbo !== 3'b000) begin fails++; $display("FAIL lu_bubble_wb got %b exp %b", wbo, 3'b000); end
    tick;
    tests++;
    if ({wbo, wb_rd} !== {3'b010, 5'd6})
      begin fails++; $display("FAIL lu_add_wb got %b exp %b", {wbo, wb_rd}, {3'b010, 5'd6}); end
    tick;
  endtask

  task automatic test_load_rd0;
    drive(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd0, 1'b0);
    tick;
    drive(1'b1, OP_R, 5'd0, 5'd0, 5'd7, 1'b0);
    #1; tests++;
    if (hz !== 3'b110) begin fails++; $display("FAIL rd0_no_stall got %b exp %b", hz, 3'b110); end
    tick;
    nop;
    tick;
    tests++;
    if (wbo !== 3'b100) begin fails++; $display("FAIL rd0_load_wb got %b exp %b", wbo, 3'b100); end
    tick;
    tests++;
    if ({wbo, wb_rd} !== {3'b010, 5'd7})
      begin fails++; $display("FAIL rd0_add_wb got %b exp %b", {wbo, wb_rd}, {3'b010, 5'd7}); end
    tick;
  endtask

  task automatic test_mem_freeze;
    drive(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd8, 1'b0);
    tick;
    drive(1'b1, OP_I, 5'd2, 5'd0, 5'd9, 1'b0);
    tick;
    drive(1'b1, OP_BRANCH, 5'd3, 5'd4, 5'd0, 1'b0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ex_redirect = (i == 1);
      #1; tests++;
      if (hz !== 3'b000) begin fails++; $display("FAIL frz_hz[%0d] got %b exp %b", i, hz, 3'b000); end
      tests++;
      if ({exo, memo, wbo} !== 9'b1000_10_000)
        begin fails++; $display("FAIL frz_stage[%0d] got %b exp %b", i, {exo, memo, wbo}, 9'b1000_10_000); end
      tick;
    end
    ex_redirect = 1'b0; mem_ready = 1'b1;
    #1; tests++;
    if (hz !== 3'b110) begin fails++; $display("FAIL frz_release_hz got %b exp %b", hz, 3'b110); end
    tick;
    nop;
    #1; tests++;
    if ({exo, memo, wbo, wb_rd} !== {4'b0100, 2'b00, 3'b110, 5'd8})
      begin fails++; $display("FAIL frz_after got %b exp %b", {exo, memo, wbo, wb_rd},
                              {4'b0100, 2'b00, 3'b110, 5'd8}); end
    tick;
  endtask

  task automatic test_redirect_loaduse;
    drive(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b0);
    tick;
    drive(1'b1, OP_R, 5'd5, 5'd2, 5'd6, 1'b0);
    ex_redirect = 1'b1;
    #1; tests++;
    if (hz !== 3'b111) begin fails++; $display("FAIL rdr_hz got %b exp %b", hz, 3'b111); end
    tick;
    ex_redirect = 1'b0; nop;
    #1; tests++;
    if ({hz, exo, memo} !== 9'b110_0000_10)
      begin fails++; $display("FAIL rdr_no_stall got %b exp %b", {hz, exo, memo}, 9'b110_0000_10); end
    tick;
    tests++;
    if ({wbo, wb_rd} !== {3'b110, 5'd5})
      begin fails++; $display("FAIL rdr_load_wb got %b exp %b", {wbo, wb_rd}, {3'b110, 5'd5}); end
    tick;
    tests++;
    if (wbo !== 3'b000) begin fails++; $display("FAIL rdr_add_flushed got %b exp %b", wbo, 3'b000); end
    tick;
  endtask

  task automatic test_ecall_nohalt;
    // Load to x17 one stage ahead in EX/MEM still stalls an ECALL.
    drive(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd17, 1'b0);
    tick;
    nop;
    tick;
    drive(1'b1, OP_SYS, 5'd0, 5'd0, 5'd0, 1'b0);
    #1; tests++;
    if (hz !== 3'b000) begin fails++; $display("FAIL ecn_load_stall got %b exp %b", hz, 3'b000); end
    tick;
    tests++;
    if (hz !== 3'b110) begin fails++; $display("FAIL ecn_resume got %b exp %b", hz, 3'b110); end
    tick;
    nop;
    for (int i = 0; i < 5; i++) begin
      #1; tests++;
      if ({hz, is_halted} !== 4'b1100)
        begin fails++; $display("FAIL ecn_idle[%0d] got %b exp %b", i, {hz, is_halted}, 4'b1100); end
      tick;
    end
  endtask

  task automatic test_ecall_redirect;
    drive(1'b1, OP_SYS, 5'd0, 5'd0, 5'd0, 1'b1);
    ex_redirect = 1'b1;
    #1; tests++;
    if (hz !== 3'b111) begin fails++; $display("FAIL ecr_flush got %b exp %b", hz, 3'b111); end
    tick;
    ex_redirect = 1'b0; nop;
    for (int i = 0; i < 8; i++) begin
      #1; tests++;
      if ({hz, is_halted} !== 4'b1100)
        begin fails++; $display("FAIL ecr_no_halt[%0d] got %b exp %b", i, {hz, is_halted}, 4'b1100); end
      tick;
    end
  endtask

  task automatic test_ecall_halt;
    drive(1'b1, OP_I, 5'd0, 5'd0, 5'd17, 1'b0);
    #1; tests++;
    if (hz !== 3'b110) begin fails++; $display("FAIL ech_addi_hz got %b exp %b", hz, 3'b110); end
    tick;
    drive(1'b1, OP_SYS, 5'd0, 5'd0, 5'd0, 1'b1);
    #1; tests++;
    if (hz !== 3'b000) begin fails++; $display("FAIL ech_stall got %b exp %b", hz, 3'b000); end
    tick;
    tests++;
    if (hz !== 3'b110) begin fails++; $display("FAIL ech_resume got %b exp %b", hz, 3'b110); end
    tick;
    nop;
    // ECALL in EX, MEM, WB, then one drain cycle: halted not yet set.
    for (int i = 0; i < 4; i++) begin
      #1; tests++;
      if ({hz, is_halted} !== 4'b0000)
        begin fails++; $display("FAIL ech_pending[%0d] got %b exp %b", i, {hz, is_halted}, 4'b0000); end
      tick;
    end
    for (int i = 0; i < 11; i++) begin
      ex_redirect = i[0];
      drive(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd3, 1'b0);
      #1; tests++;
      if ({hz, is_halted} !== 4'b0001)
        begin fails++; $display("FAIL ech_halted[%0d] got %b exp %b", i, {hz, is_halted}, 4'b0001); end
      tick;
    end
    reset = 1'b1;
    tick;
    reset = 1'b0; ex_redirect = 1'b0; nop;
    #1; tests++;
    if ({hz, is_halted} !== 4'b1100)
      begin fails++; $display("FAIL ech_reset_clear got %b exp %b", {hz, is_halted}, 4'b1100); end
    tick;
  endtask

  initial begin
    reset = 1'b1; ex_redirect = 1'b0; mem_ready = 1'b1;
    nop;
    test_reset;
    settle;
    test_decode;
    settle;
    test_load_use;
    settle;
    test_load_rd0;
    settle;
    test_mem_freeze;
    settle;
    test_redirect_loaduse;
    settle;
    test_ecall_nohalt;
    settle;
    test_ecall_redirect;
    settle;
    test_ecall_halt;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
